// File: rtl/tag_array_pkg.sv
// Shared defaults and flush-engine state encoding for the parametrised tag array.
package tag_array_pkg;

  localparam int DEF_TAG_W = 26;
  localparam int DEF_SETS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

endpackage

// File: rtl/tag_entry.sv
// One set of the tag store: a tag register plus its valid bit.
module tag_entry #(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv,
  input  logic             clr,
  output logic [TAG_W-1:0] tag,
  output logic             valid
);

  // A write beats a same-cycle invalidate so a refill is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      if (wr) begin
        tag   <= wr_tag;
        valid <= 1'b1;
      end else if (inv || clr) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tag_array_param.sv
// Single-way tag store with registered lookup, per-set invalidate and a sequential flush engine.
module tag_array_param
  import tag_array_pkg::*;
#(
  parameter  int TAG_W = DEF_TAG_W,
  parameter  int SETS  = DEF_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_line_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_index,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done
);

  flush_state_t state, state_next;
  logic [IDX_W-1:0] ptr;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  wr_sel, inv_sel, clr_sel;
  logic             accept;
  logic             lookup;
  logic             start;
  logic             sweep_last;

  assign start      = (state == IDLE) && flush_start;
  assign accept     = req_ready && !start;
  assign lookup     = accept && req_valid;
  assign sweep_last = (ptr == IDX_W'(SETS - 1));

  always_comb begin
    wr_sel  = '0;
    inv_sel = '0;
    clr_sel = '0;
    for (int i = 0; i < SETS; i++) begin
      wr_sel[i]  = accept && wr_en  && (wr_index  == IDX_W'(i));
      inv_sel[i] = accept && inv_en && (inv_index == IDX_W'(i));
      clr_sel[i] = (state == SWEEP) && (ptr == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < SETS; g++) begin : g_set
    tag_entry #(.TAG_W(TAG_W)) u_entry (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr_sel[g]),
      .wr_tag (wr_tag),
      .inv    (inv_sel[g]),
      .clr    (clr_sel[g]),
      .tag    (tag_q[g]),
      .valid  (valid_q[g])
    );
  end

  // Response registers sample the array before this edge's write/invalidate lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_tag        <= '0;
      rsp_line_valid <= 1'b0;
    end else begin
      rsp_valid <= lookup;
      if (lookup) begin
        rsp_tag        <= tag_q[req_index];
        rsp_line_valid <= valid_q[req_index];
        rsp_hit        <= valid_q[req_index] && (tag_q[req_index] == req_tag);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        ptr <= '0;
      end else if (state == SWEEP) begin
        ptr <= ptr + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_start) state_next = SWEEP;
      SWEEP:   if (sweep_last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flush_busy = (state == SWEEP);
    flush_done = (state == DONE);
    req_ready  = (state != SWEEP);
  end

endmodule

// File: tb/tb_tag_array_param.sv
// Directed bench: default 4x26 array for functional cases, 8x20 array for reset during flush.
module tb_tag_array_param;

  logic clk;
  int   checks;
  int   errors;

  // Instance A: default parameters
  logic        a_reset;
  logic        a_req_valid;
  logic [1:0]  a_req_index;
  logic [25:0] a_req_tag;
  logic        a_req_ready;
  logic        a_rsp_valid;
  logic        a_rsp_hit;
  logic [25:0] a_rsp_tag;
  logic        a_rsp_line_valid;
  logic        a_wr_en;
  logic [1:0]  a_wr_index;
  logic [25:0] a_wr_tag;
  logic        a_inv_en;
  logic [1:0]  a_inv_index;
  logic        a_flush_start;
  logic        a_flush_busy;
  logic        a_flush_done;

  // Instance B: SETS=8, TAG_W=20
  logic        b_reset;
  logic        b_req_valid;
  logic [2:0]  b_req_index;
  logic [19:0] b_req_tag;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic        b_rsp_hit;
  logic [19:0] b_rsp_tag;
  logic        b_rsp_line_valid;
  logic        b_wr_en;
  logic [2:0]  b_wr_index;
  logic [19:0] b_wr_tag;
  logic        b_inv_en;
  logic [2:0]  b_inv_index;
  logic        b_flush_start;
  logic        b_flush_busy;
  logic        b_flush_done;

  tag_array_param dut_a (
    .clk            (clk),
    .reset          (a_reset),
    .req_valid      (a_req_valid),
    .req_index      (a_req_index),
    .req_tag        (a_req_tag),
    .req_ready      (a_req_ready),
    .rsp_valid      (a_rsp_valid),
    .rsp_hit        (a_rsp_hit),
    .rsp_tag        (a_rsp_tag),
    .rsp_line_valid (a_rsp_line_valid),
    .wr_en          (a_wr_en),
    .wr_index       (a_wr_index),
    .wr_tag         (a_wr_tag),
    .inv_en         (a_inv_en),
    .inv_index      (a_inv_index),
    .flush_start    (a_flush_start),
    .flush_busy     (a_flush_busy),
    .flush_done     (a_flush_done)
  );

  tag_array_param #(.TAG_W(20), .SETS(8)) dut_b (
    .clk            (clk),
    .reset          (b_reset),
    .req_valid      (b_req_valid),
    .req_index      (b_req_index),
    .req_tag        (b_req_tag),
    .req_ready      (b_req_ready),
    .rsp_valid      (b_rsp_valid),
    .rsp_hit        (b_rsp_hit),
    .rsp_tag        (b_rsp_tag),
    .rsp_line_valid (b_rsp_line_valid),
    .wr_en          (b_wr_en),
    .wr_index       (b_wr_index),
    .wr_tag         (b_wr_tag),
    .inv_en         (b_inv_en),
    .inv_index      (b_inv_index),
    .flush_start    (b_flush_start),
    .flush_busy     (b_flush_busy),
    .flush_done     (b_flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus;
    a_req_valid = 0; a_req_index = '0; a_req_tag = '0;
    a_wr_en = 0; a_wr_index = '0; a_wr_tag = '0;
    a_inv_en = 0; a_inv_index = '0; a_flush_start = 0;
    b_req_valid = 0; b_req_index = '0; b_req_tag = '0;
    b_wr_en = 0; b_wr_index = '0; b_wr_tag = '0;
    b_inv_en = 0; b_inv_index = '0; b_flush_start = 0;
  endtask

  task automatic lookupA(input logic [1:0] idx, input logic [25:0] tag);
    applyStimulus();
    a_req_valid = 1; a_req_index = idx; a_req_tag = tag;
    step();
    applyStimulus();
  endtask

  task automatic lookupB(input logic [2:0] idx, input logic [19:0] tag);
    applyStimulus();
    b_req_valid = 1; b_req_index = idx; b_req_tag = tag;
    step();
    applyStimulus();
  endtask

  task automatic writeA(input logic [1:0] idx, input logic [25:0] tag);
    applyStimulus();
    a_wr_en = 1; a_wr_index = idx; a_wr_tag = tag;
    step();
    applyStimulus();
  endtask

  logic [25:0] fill_tags [4];

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus();
    a_reset = 0;
    b_reset = 0;
    step();
    step();
    checkOutput("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("rst_rsp_tag", 32'(a_rsp_tag), 32'd0);
    checkOutput("rst_req_ready", 32'(a_req_ready), 32'd1);
    checkOutput("rst_flush_busy", 32'(a_flush_busy), 32'd0);
    checkOutput("rst_flush_done", 32'(a_flush_done), 32'd0);
    a_reset = 1;
    b_reset = 1;
    step();

    // Lookup on an empty array
    lookupA(2'd2, 26'h0ABCDEF);
    checkOutput("empty_rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("empty_hit", 32'(a_rsp_hit), 32'd0);
    checkOutput("empty_line_valid", 32'(a_rsp_line_valid), 32'd0);
    checkOutput("empty_tag", 32'(a_rsp_tag), 32'd0);
    step();
    checkOutput("rsp_valid_pulse", 32'(a_rsp_valid), 32'd0);

    // Write then hit / miss
    writeA(2'd1, 26'h1234567);
    lookupA(2'd1, 26'h1234567);
    checkOutput("wr_hit", 32'(a_rsp_hit), 32'd1);
    checkOutput("wr_line_valid", 32'(a_rsp_line_valid), 32'd1);
    lookupA(2'd1, 26'h1234568);
    checkOutput("wr_miss_hit", 32'(a_rsp_hit), 32'd0);
    checkOutput("wr_miss_tag", 32'(a_rsp_tag), 32'h1234567);

    // Read-before-write ordering
    applyStimulus();
    a_wr_en = 1; a_wr_index = 2'd3; a_wr_tag = 26'h5;
    a_req_valid = 1; a_req_index = 2'd3; a_req_tag = 26'h5;
    step();
    applyStimulus();
    checkOutput("rbw_rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("rbw_old_hit", 32'(a_rsp_hit), 32'd0);
    checkOutput("rbw_old_line_valid", 32'(a_rsp_line_valid), 32'd0);
    lookupA(2'd3, 26'h5);
    checkOutput("rbw_new_hit", 32'(a_rsp_hit), 32'd1);

    // Write-vs-invalidate priority and tag retention on invalidate
    writeA(2'd0, 26'hAA);
    writeA(2'd2, 26'hBB);
    applyStimulus();
    a_wr_en = 1; a_wr_index = 2'd2; a_wr_tag = 26'h7;
    a_inv_en = 1; a_inv_index = 2'd2;
    step();
    applyStimulus();
    a_inv_en = 1; a_inv_index = 2'd0;
    step();
    applyStimulus();
    lookupA(2'd2, 26'h7);
    checkOutput("wr_beats_inv_hit", 32'(a_rsp_hit), 32'd1);
    lookupA(2'd0, 26'hAA);
    checkOutput("inv_line_valid", 32'(a_rsp_line_valid), 32'd0);
    checkOutput("inv_hit", 32'(a_rsp_hit), 32'd0);
    checkOutput("inv_tag_kept", 32'(a_rsp_tag), 32'hAA);

    // Flush: fill all sets, then sweep while ignoring traffic
    writeA(2'd0, 26'h11);
    fill_tags[0] = 26'h11; fill_tags[1] = 26'h1234567;
    fill_tags[2] = 26'h7;  fill_tags[3] = 26'h5;
    lookupA(2'd0, 26'h11);
    checkOutput("prefill_hit0", 32'(a_rsp_hit), 32'd1);
    applyStimulus();
    a_flush_start = 1;
    step();
    applyStimulus();
    a_req_valid = 1; a_req_index = 2'd1; a_req_tag = 26'h1234567;
    a_wr_en = 1; a_wr_index = 2'd1; a_wr_tag = 26'h99;
    a_inv_en = 1; a_inv_index = 2'd3;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("flush_busy_c%0d", k + 1), 32'(a_flush_busy), 32'd1);
      checkOutput($sformatf("flush_ready_c%0d", k + 1), 32'(a_req_ready), 32'd0);
      checkOutput($sformatf("flush_done_c%0d", k + 1), 32'(a_flush_done), 32'd0);
      checkOutput($sformatf("flush_rsp_c%0d", k + 1), 32'(a_rsp_valid), 32'd0);
      step();
    end
    applyStimulus();
    checkOutput("flush_done_pulse", 32'(a_flush_done), 32'd1);
    checkOutput("flush_busy_done", 32'(a_flush_busy), 32'd0);
    checkOutput("flush_ready_done", 32'(a_req_ready), 32'd1);
    checkOutput("flush_rsp_last", 32'(a_rsp_valid), 32'd0);
    step();
    checkOutput("flush_done_end", 32'(a_flush_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      lookupA(2'(i), fill_tags[i]);
      checkOutput($sformatf("post_flush_lv%0d", i), 32'(a_rsp_line_valid), 32'd0);
      checkOutput($sformatf("post_flush_hit%0d", i), 32'(a_rsp_hit), 32'd0);
      checkOutput($sformatf("post_flush_tag%0d", i), 32'(a_rsp_tag), 32'(fill_tags[i]));
    end

    // Instance B: reset asserted in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      b_wr_en = 1; b_wr_index = 3'(i); b_wr_tag = 20'((i + 1) * 32'h111);
      step();
    end
    lookupB(3'd5, 20'h666);
    checkOutput("b_prefill_hit", 32'(b_rsp_hit), 32'd1);
    applyStimulus();
    b_flush_start = 1;
    step();
    applyStimulus();
    step();
    step();
    step();
    checkOutput("b_busy_ptr3", 32'(b_flush_busy), 32'd1);
    #2;
    b_reset = 0;
    #1;
    checkOutput("b_rst_busy", 32'(b_flush_busy), 32'd0);
    checkOutput("b_rst_done", 32'(b_flush_done), 32'd0);
    checkOutput("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    checkOutput("b_rst_hit", 32'(b_rsp_hit), 32'd0);
    checkOutput("b_rst_tag", 32'(b_rsp_tag), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput($sformatf("b_no_done_%0d", k), 32'(b_flush_done), 32'd0);
    end
    b_reset = 1;
    step();
    checkOutput("b_ready_after", 32'(b_req_ready), 32'd1);
    checkOutput("b_busy_after", 32'(b_flush_busy), 32'd0);
    checkOutput("b_done_after", 32'(b_flush_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      lookupB(3'(i), 20'((i + 1) * 32'h111));
      checkOutput($sformatf("b_lv%0d", i), 32'(b_rsp_line_valid), 32'd0);
      checkOutput($sformatf("b_hit%0d", i), 32'(b_rsp_hit), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
